alu_result_fifo: RTL and testbench

//   Buffers each ALU result (sum, carry, zero, overflow, plus the select code that produced it) in a small FIFO.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_fifo_ctrl.sv | 82 ++++++++
 rtl/alu_result_fifo.sv | 104 ++++++++++
 tb/tb_alu_result_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: select codes, FIFO result record and controller states.
package alu_pkg;

    localparam int ALU_SEL_W  = 3;
    localparam int ALU_DATA_W = 4;

    typedef enum logic [ALU_SEL_W-1:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        NOT = 3'd2,
        AND = 3'd3,
        OR  = 3'd4,
        XOR = 3'd5,
        LT  = 3'd6,
        EQ  = 3'd7
    } alu_sel_e;

    typedef struct packed {
        logic [ALU_SEL_W-1:0]  sel;
        logic [ALU_DATA_W-1:0] s;
        logic                  c;
        logic                  zero;
        logic                  overflow;
    } alu_result_t;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/alu_fifo_ctrl.sv
// FIFO controller: read/write pointers, occupancy level and EMPTY/PARTIAL/FULL state.
module alu_fifo_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             push,
    output logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(DEPTH - 1);

    fifo_state_e      state_reg, state_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0] level_reg, level_next;

    // The state already encodes level==0 / level==DEPTH, so flags come from it.
    assign full   = (state_reg == ST_FULL);
    assign empty  = (state_reg == ST_EMPTY);
    assign push   = in_valid & ~full;
    assign pop    = out_ready & ~empty;
    assign wr_ptr = wr_ptr_reg;
    assign rd_ptr = rd_ptr_reg;
    assign level  = level_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_EMPTY;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_ONE;
            2'b01:   level_next = level_reg - LVL_ONE;
            default: level_next = level_reg;
        endcase
        case (state_reg)
            ST_EMPTY: begin
                if (push)
                    state_next = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (push && !pop && level_reg == LVL_LAST)
                    state_next = ST_FULL;
                else if (pop && !push && level_reg == LVL_ONE)
                    state_next = ST_EMPTY;
            end
            ST_FULL: begin
                if (pop)
                    state_next = ST_PARTIAL;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO of ALU results with valid/ready on both sides.
// Optional push statistics counters enabled by defining ALU_FIFO_STATS_EN.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_sel,
    input  logic [WIDTH-1:0]         in_s,
    input  logic                     in_c,
    input  logic                     in_zero,
    input  logic                     in_overflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_sel,
    output logic [WIDTH-1:0]         out_s,
    output logic                     out_c,
    output logic                     out_zero,
    output logic                     out_overflow,
`ifdef ALU_FIFO_STATS_EN
    input  logic                     stats_clr,
    output logic [7:0]               ovf_cnt,
    output logic [7:0]               carry_cnt,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             push, pop, full, empty;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    alu_result_t      storage [DEPTH];
    alu_result_t      wr_entry, head;

    alu_fifo_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .LVL_W (LVL_W)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .push      (push),
        .pop       (pop),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    assign in_ready  = ~full;
    assign out_valid = ~empty;

    // The record's s field is sized by ALU_DATA_W; casts keep WIDTH overrides explicit.
    assign wr_entry.sel      = in_sel;
    assign wr_entry.s        = ALU_DATA_W'(in_s);
    assign wr_entry.c        = in_c;
    assign wr_entry.zero     = in_zero;
    assign wr_entry.overflow = in_overflow;

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push)
            storage[wr_ptr] <= wr_entry;
    end

    assign head         = storage[rd_ptr];
    assign out_sel      = head.sel;
    assign out_s        = WIDTH'(head.s);
    assign out_c        = head.c;
    assign out_zero     = head.zero;
    assign out_overflow = head.overflow;

`ifdef ALU_FIFO_STATS_EN
    logic [7:0] ovf_cnt_reg, carry_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_reg   <= '0;
            carry_cnt_reg <= '0;
        end else if (stats_clr) begin
            ovf_cnt_reg   <= '0;
            carry_cnt_reg <= '0;
        end else if (push) begin
            if (in_overflow && ovf_cnt_reg != 8'hFF)
                ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
            if (in_c && carry_cnt_reg != 8'hFF)
                carry_cnt_reg <= carry_cnt_reg + 8'd1;
        end
    end

    assign ovf_cnt   = ovf_cnt_reg;
    assign carry_cnt = carry_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (DEPTH=4, WIDTH=4).
module tb_alu_result_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_sel;
    logic [3:0] in_s;
    logic       in_c;
    logic       in_zero;
    logic       in_overflow;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_sel;
    logic [3:0] out_s;
    logic       out_c;
    logic       out_zero;
    logic       out_overflow;
    logic [2:0] level;
`ifdef ALU_FIFO_STATS_EN
    logic       stats_clr;
    logic [7:0] ovf_cnt;
    logic [7:0] carry_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_result_fifo #(.WIDTH(4), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_s         (in_s),
        .in_c         (in_c),
        .in_zero      (in_zero),
        .in_overflow  (in_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sel      (out_sel),
        .out_s        (out_s),
        .out_c        (out_c),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
`ifdef ALU_FIFO_STATS_EN
        .stats_clr    (stats_clr),
        .ovf_cnt      (ovf_cnt),
        .carry_cnt    (carry_cnt),
`endif
        .level        (level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic [3:0] s,
                         input logic c, input logic z, input logic ov);
        in_valid    = v;
        in_sel      = sel;
        in_s        = s;
        in_c        = c;
        in_zero     = z;
        in_overflow = ov;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 4'hF, 1'b1, 1'b1, 1'b1);
`ifdef ALU_FIFO_STATS_EN
        stats_clr = 1'b0;
`endif
        // 1: reset held with in_valid high
        tick(); tick(); tick();
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        drive(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("post_rst_level", 32'(level), 32'd0);

        // 2: two pushes, then two pops
        drive(1'b1, 3'd0, 4'h7, 1'b0, 1'b0, 1'b0);
        tick();
        check("t2_level1", 32'(level), 32'd1);
        check("t2_head_s", 32'(out_s), 32'h7);
        check("t2_head_sel", 32'(out_sel), 32'd0);
        drive(1'b1, 3'd1, 4'h0, 1'b1, 1'b1, 1'b0);
        tick();
        check("t2_level2", 32'(level), 32'd2);
        check("t2_head_s_hold", 32'(out_s), 32'h7);
        drive(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        check("t2_level_pop1", 32'(level), 32'd1);
        check("t2_head2", 32'({out_sel, out_s, out_c, out_zero, out_overflow}), 32'({3'd1, 4'h0, 1'b1, 1'b1, 1'b0}));
        tick();
        check("t2_level_pop2", 32'(level), 32'd0);
        check("t2_empty", 32'(out_valid), 32'd0);
        tick();
        check("t2_no_underflow", 32'(level), 32'd0);
        out_ready = 1'b0;

        // 3: five pushes into a 4-deep FIFO, then drain
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 3'(i), 4'(i), 1'b0, 1'b0, i[0]);
            tick();
        end
        check("t3_level_full", 32'(level), 32'd4);
        check("t3_in_ready", 32'(in_ready), 32'd0);
        drive(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t3_drain", 32'({out_sel, out_s, out_overflow}), 32'({3'(i), 4'(i), i[0]}));
            tick();
        end
        check("t3_drained", 32'(level), 32'd0);
        out_ready = 1'b0;

        // 4: full with push and pop both requested
        for (int i = 8; i <= 11; i++) begin
            drive(1'b1, 3'd5, 4'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 3'd6, 4'hC, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        check("t4_full_ready", 32'(in_ready), 32'd0);
        tick();
        check("t4_pop_only", 32'(level), 32'd3);
        check("t4_ready_back", 32'(in_ready), 32'd1);
        check("t4_head9", 32'(out_s), 32'h9);
        tick();
        check("t4_push_pop", 32'(level), 32'd3);
        check("t4_headA", 32'(out_s), 32'hA);
        drive(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check("t4_headB", 32'(out_s), 32'hB);
        tick();
        check("t4_headC", 32'({out_sel, out_s}), 32'({3'd6, 4'hC}));
        tick();
        check("t4_drained", 32'(level), 32'd0);
        out_ready = 1'b0;

        // 5: steady push+pop stream wraps both pointers
        drive(1'b1, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 3'(i), 4'(i), 1'b0, 1'b0, 1'b0);
            check("t5_stream", 32'({out_sel, out_s}), 32'({3'(i - 1), 4'(i - 1)}));
            tick();
        end
        check("t5_level", 32'(level), 32'd1);
        check("t5_last", 32'(out_s), 32'h9);
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 4'hE, 1'b0, 1'b0, 1'b0);
        tick();
        check("t5_level2", 32'(level), 32'd2);
        rst = 1'b1;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_level", 32'(level), 32'd0);
        check("t5_async_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check("t5_after_rst", 32'(level), 32'd0);

`ifdef ALU_FIFO_STATS_EN
        // 6: saturating overflow counter and clear priority
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 3'd0, 4'(i), i[0], 1'b0, 1'b1);
            tick();
        end
        check("t6_ovf_sat", 32'(ovf_cnt), 32'hFF);
        check("t6_carry", 32'(carry_cnt), 32'd150);
        stats_clr = 1'b1;
        drive(1'b1, 3'd0, 4'h1, 1'b1, 1'b0, 1'b1);
        tick();
        stats_clr = 1'b0;
        drive(1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("t6_clr_ovf", 32'(ovf_cnt), 32'd0);
        check("t6_clr_carry", 32'(carry_cnt), 32'd0);
        out_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
